// File: rtl/score_combo_tracker.sv
// Score/combo producer for the 7-segment display path.
// Turns per-note judgement strobes into saturating binary score, combo,
// max_combo and miss counts. A small session FSM gates the counting, and a
// sticky success flag records when the score target has been reached.
module score_combo_tracker #(
    parameter int unsigned SCORE_MAX    = 999,
    parameter int unsigned COMBO_MAX    = 999,
    parameter int unsigned SCORE_TARGET = 500,
    parameter int unsigned MUL2_AT      = 10,
    parameter int unsigned MUL3_AT      = 30,
    parameter int unsigned MUL4_AT      = 50
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_end,
    input  logic       hit_valid,
    input  logic [1:0] hit_grade,
    output logic [9:0] score,
    output logic [9:0] combo,
    output logic [9:0] max_combo,
    output logic [9:0] miss_cnt,
    output logic       success,
    output logic       playing
);

    localparam int unsigned W  = 10;   // counter width
    localparam int unsigned SW = W + 1; // one extra bit so sums cannot wrap
    localparam int unsigned PW = 4;    // points width (max 3 x 4 = 12)

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   score_q, score_d;
    logic [W-1:0]   combo_q, combo_d;
    logic [W-1:0]   max_combo_q, max_combo_d;
    logic [W-1:0]   miss_cnt_q, miss_cnt_d;
    logic           success_q, success_d;
    logic           playing_q;

    logic [2:0]     mult;
    logic [PW-1:0]  points;
    logic [SW-1:0]  score_sum;
    logic [W-1:0]   score_sat;
    logic [SW-1:0]  combo_inc;
    logic [W-1:0]   combo_sat;
    logic [SW-1:0]  miss_inc;
    logic [W-1:0]   miss_sat;
    logic           hit_take;

    // Multiplier chosen from the combo value before the current hit
    always_comb begin
        mult = 3'd4;
        if (combo_q < W'(MUL2_AT)) begin
            mult = 3'd1;
        end else if (combo_q < W'(MUL3_AT)) begin
            mult = 3'd2;
        end else if (combo_q < W'(MUL4_AT)) begin
            mult = 3'd3;
        end
    end

    // Saturating arithmetic for every counter a hit can touch
    always_comb begin
        points    = PW'(hit_grade) * PW'(mult);
        score_sum = SW'(score_q) + SW'(points);
        score_sat = (score_sum > SW'(SCORE_MAX)) ? W'(SCORE_MAX) : score_sum[W-1:0];
        combo_inc = SW'(combo_q) + SW'(1);
        combo_sat = (combo_inc > SW'(COMBO_MAX)) ? W'(COMBO_MAX) : combo_inc[W-1:0];
        miss_inc  = SW'(miss_cnt_q) + SW'(1);
        miss_sat  = (miss_inc > SW'(COMBO_MAX)) ? W'(COMBO_MAX) : miss_inc[W-1:0];
    end

    // Next counter values for an accepted hit; hold otherwise
    always_comb begin
        hit_take    = hit_valid && (state_q == S_PLAY);
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        miss_cnt_d  = miss_cnt_q;
        success_d   = success_q;
        if (hit_take) begin
            if (hit_grade != 2'd0) begin
                score_d     = score_sat;
                combo_d     = combo_sat;
                max_combo_d = (combo_sat > max_combo_q) ? combo_sat : max_combo_q;
                success_d   = success_q || (score_sat >= W'(SCORE_TARGET));
            end else begin
                combo_d    = '0;
                miss_cnt_d = miss_sat;
            end
        end
    end

    // Session FSM and counter registers; start beats end beats hit
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            playing_q   <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            miss_cnt_q  <= '0;
            success_q   <= 1'b0;
        end else if (game_start) begin
            state_q     <= S_PLAY;
            playing_q   <= 1'b1;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            miss_cnt_q  <= '0;
            success_q   <= 1'b0;
        end else if (game_end) begin
            if (state_q == S_PLAY) begin
                state_q   <= S_DONE;
                playing_q <= 1'b0;
            end
        end else begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            miss_cnt_q  <= miss_cnt_d;
            success_q   <= success_d;
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign miss_cnt  = miss_cnt_q;
    assign success   = success_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_score_combo_tracker.sv
// Directed + randomized bench for score_combo_tracker with a behavioural model.
module tb_score_combo_tracker;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       game_end = 1'b0;
    logic       hit_valid = 1'b0;
    logic [1:0] hit_grade = 2'd0;
    logic [9:0] score, combo, max_combo, miss_cnt;
    logic       success, playing;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: session phase 0=idle 1=play 2=done, plain integer counters
    int m_phase, m_score, m_combo, m_max, m_miss, m_succ;

    score_combo_tracker dut (
        .clock      (clock),
        .rst        (rst),
        .game_start (game_start),
        .game_end   (game_end),
        .hit_valid  (hit_valid),
        .hit_grade  (hit_grade),
        .score      (score),
        .combo      (combo),
        .max_combo  (max_combo),
        .miss_cnt   (miss_cnt),
        .success    (success),
        .playing    (playing)
    );

    always #5 clock = ~clock;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int multiplier(input int c);
        if (c < 10) return 1;
        if (c < 30) return 2;
        if (c < 50) return 3;
        return 4;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0; m_succ = 0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit v, input int g);
        if (s) begin
            m_phase = 1; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0; m_succ = 0;
        end else if (e) begin
            if (m_phase == 1) m_phase = 2;
        end else if (v && m_phase == 1) begin
            if (g == 0) begin
                m_combo = 0;
                m_miss  = imin(m_miss + 1, 999);
            end else begin
                m_score = imin(m_score + g * multiplier(m_combo), 999);
                m_combo = imin(m_combo + 1, 999);
                if (m_combo > m_max) m_max = m_combo;
                if (m_score >= 500) m_succ = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"},     16'(score),     16'(m_score));
        chk({tag, ".combo"},     16'(combo),     16'(m_combo));
        chk({tag, ".max_combo"}, 16'(max_combo), 16'(m_max));
        chk({tag, ".miss_cnt"},  16'(miss_cnt),  16'(m_miss));
        chk({tag, ".success"},   16'(success),   16'(m_succ));
        chk({tag, ".playing"},   16'(playing),   16'(m_phase == 1));
    endtask

    // One clock of stimulus; outputs checked 1 time unit after the edge
    task automatic step(input bit s, input bit e, input bit v, input int g, input string tag);
        game_start = s;
        game_end   = e;
        hit_valid  = v;
        hit_grade  = 2'(g);
        @(posedge clock);
        #1;
        game_start = 1'b0;
        game_end   = 1'b0;
        hit_valid  = 1'b0;
        model_step(s, e, v, g);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clock);
        #1;
        rst = 1'b0;
        check_all({tag, ".held"});
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("por");
        rst = 1'b0;

        // Hits before any game_start are ignored
        for (int i = 0; i < 3; i++) step(0, 0, 1, 3, "idle_hit");
        step(0, 1, 0, 0, "idle_end");

        // Build score 37, then reset mid-session
        step(1, 0, 0, 0, "start_a");
        for (int i = 0; i < 9; i++) step(0, 0, 1, 3, "build37");
        step(0, 0, 1, 2, "build37");
        step(0, 0, 1, 3, "build37");
        step(0, 0, 1, 1, "build37");
        chk("score_37", 16'(score), 16'd37);
        do_reset("mid_rst");
        chk("rst_playing", 16'(playing), 16'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 3, "post_rst_hit");

        // Multiplier step-up at combo 10
        step(1, 0, 0, 0, "start_b");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 3, "perfect");
        chk("score_30", 16'(score), 16'd30);
        chk("combo_10", 16'(combo), 16'd10);
        step(0, 0, 1, 3, "perfect11");
        chk("score_36", 16'(score), 16'd36);
        step(0, 0, 1, 3, "perfect12");
        chk("score_42", 16'(score), 16'd42);
        chk("combo_12", 16'(combo), 16'd12);
        chk("max_12",   16'(max_combo), 16'd12);

        // Miss then good hit
        step(0, 0, 1, 0, "miss");
        chk("miss_combo0", 16'(combo), 16'd0);
        chk("miss_cnt1",   16'(miss_cnt), 16'd1);
        chk("miss_score",  16'(score), 16'd42);
        chk("miss_max",    16'(max_combo), 16'd12);
        step(0, 0, 1, 1, "good");
        chk("good_score",  16'(score), 16'd43);
        chk("good_combo",  16'(combo), 16'd1);

        // Drive score into saturation with perfect hits (bounded)
        for (int i = 0; i < 300 && m_score < 999; i++) step(0, 0, 1, 3, "climb");
        chk("sat_reached", 16'(score), 16'd999);
        chk("succ_set",    16'(success), 16'd1);
        step(0, 0, 1, 3, "sat_hold");
        chk("sat_hold_score", 16'(score), 16'd999);
        chk("sat_hold_combo", 16'(combo), 16'(m_combo));

        // game_end drops a coincident hit; DONE freezes everything
        step(0, 1, 1, 3, "end_hit");
        chk("done_playing", 16'(playing), 16'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, i, "frozen");
        step(0, 1, 0, 0, "done_end");
        step(1, 0, 1, 3, "restart");
        chk("restart_score",   16'(score), 16'd0);
        chk("restart_playing", 16'(playing), 16'd1);

        // Back-to-back hits every cycle, alternating perfect and miss
        for (int i = 0; i < 20; i++) step(0, 0, 1, (i % 2 == 0) ? 3 : 0, "alt");
        chk("alt_score", 16'(score), 16'd30);
        chk("alt_miss",  16'(miss_cnt), 16'd10);
        chk("alt_combo", 16'(combo), 16'd0);

        // Restart within PLAY, then saturate combo and miss_cnt
        step(1, 0, 0, 0, "restart_play");
        for (int i = 0; i < 1003; i++) step(0, 0, 1, 1, "combo_sat");
        chk("combo_999", 16'(combo), 16'd999);
        chk("max_999",   16'(max_combo), 16'd999);
        for (int i = 0; i < 1003; i++) step(0, 0, 1, 0, "miss_sat");
        chk("miss_999",  16'(miss_cnt), 16'd999);
        chk("max_kept",  16'(max_combo), 16'd999);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 39));
            step(r == 0, r == 1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), "rand");
        end

        do_reset("final_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
